// File: rtl/port_seq_pkg.sv
// Shared types and constants for the port access sequencer and its arbiter.
package port_seq_pkg;

    localparam int PORT_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEL_LO = 3'd1,
        SEL_HI = 3'd2,
        SETUP  = 3'd3,
        STROBE = 3'd4,
        HOLD   = 3'd5,
        DONE   = 3'd6
    } state_t;

    // States in which a write transfer keeps its data on the port bus.
    function automatic logic drives_bus(input state_t st);
        case (st)
            SEL_LO, SEL_HI, SETUP, STROBE, HOLD: drives_bus = 1'b1;
            default:                             drives_bus = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/port_access_sequencer_chk.sv
// Protocol checks on the select and strobe outputs of the sequencer.
module port_access_sequencer_chk #(
    parameter int unsigned STROBE_CYC = 32'd2
) (
    input logic clk,
    input logic reset,
    input logic portsel_n,
    input logic port_wr_n,
    input logic port_rd_n
);

    if (STROBE_CYC == 32'd0) begin : g_bad_strobe
        $error("STROBE_CYC must be at least 1");
    end

    a_one_strobe: assert property (@(posedge clk) disable iff (reset)
        (port_wr_n || port_rd_n));

    a_no_sel_overlap: assert property (@(posedge clk) disable iff (reset)
        (portsel_n || (port_wr_n && port_rd_n)));

endmodule

// File: rtl/port_rr_arbiter.sv
// Two-way round-robin arbiter; the parent records the winner in rr_last.
module port_rr_arbiter
    import port_seq_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] grant
);

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (rr_last == REQ_B) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/port_access_sequencer.sv
// Shares the port selector/decoder between two requesters and sequences
// select, setup, strobe and hold for each transfer.
module port_access_sequencer
    import port_seq_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 32'd1,
    parameter int unsigned STROBE_CYC = 32'd2,
    parameter int unsigned HOLD_CYC   = 32'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic [PORT_W-1:0] port_a,
    input  logic              wr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [PORT_W-1:0] port_b,
    input  logic              wr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] port_bus_in,
    output logic [DATA_W-1:0] port_bus_out,
    output logic              port_bus_oe,
    output logic [DATA_W-1:0] sel_data,
    output logic              _portsel_in,
    output logic              _port_wr,
    output logic              _port_rd,
    output logic              busy
);

    localparam logic [CNT_W-1:0] STROBE_LD    = CNT_W'(STROBE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LD      = CNT_W'(HOLD_CYC - 32'd1);
    localparam logic [CNT_W-1:0] AFTER_SEL_LD = (SETUP_CYC != 32'd0) ?
                                                CNT_W'(SETUP_CYC - 32'd1) : STROBE_LD;
    localparam state_t AFTER_SEL_ST = (SETUP_CYC != 32'd0) ? SETUP : STROBE;
    localparam state_t AFTER_STB_ST = (HOLD_CYC != 32'd0) ? HOLD : DONE;

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               gnt_r, gnt_nxt_s;
    logic [PORT_W-1:0]  port_r, port_nxt_s, last_port_r;
    logic               wr_r, wr_nxt_s;
    logic [DATA_W-1:0]  wdata_r, wdata_nxt_s;
    logic               rr_last_r, sel_valid_r;
    logic [1:0]         grant_s;
    logic               portsel_n_r, port_wr_n_r, port_rd_n_r;
    logic               ack_a_r, ack_b_r, busy_r, bus_oe_r;
    logic [DATA_W-1:0]  bus_out_r, sel_data_r, rd_data_r;

    port_rr_arbiter u_arb (
        .req     ({req_b, req_a}),
        .rr_last (rr_last_r),
        .grant   (grant_s)
    );

    port_access_sequencer_chk #(.STROBE_CYC(STROBE_CYC)) u_chk (
        .clk       (clk),
        .reset     (reset),
        .portsel_n (portsel_n_r),
        .port_wr_n (port_wr_n_r),
        .port_rd_n (port_rd_n_r)
    );

    // Arbitration, next state and the shared SETUP/STROBE/HOLD counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        gnt_nxt_s   = gnt_r;
        port_nxt_s  = port_r;
        wr_nxt_s    = wr_r;
        wdata_nxt_s = wdata_r;
        case (state_r)
            IDLE: begin
                if (grant_s != 2'b00) begin
                    gnt_nxt_s   = grant_s[REQ_B];
                    port_nxt_s  = grant_s[REQ_B] ? port_b  : port_a;
                    wr_nxt_s    = grant_s[REQ_B] ? wr_b    : wr_a;
                    wdata_nxt_s = grant_s[REQ_B] ? wdata_b : wdata_a;
                    if (sel_valid_r && (port_nxt_s == last_port_r)) begin
                        state_nxt_s = AFTER_SEL_ST;
                        cnt_nxt_s   = AFTER_SEL_LD;
                    end else begin
                        state_nxt_s = SEL_LO;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEL_LO: state_nxt_s = SEL_HI;
            SEL_HI: begin
                state_nxt_s = AFTER_SEL_ST;
                cnt_nxt_s   = AFTER_SEL_LD;
            end
            SETUP: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = STROBE;
                    cnt_nxt_s   = STROBE_LD;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = AFTER_STB_ST;
                    cnt_nxt_s   = HOLD_LD;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = DONE;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sequencer state, latched request fields and select bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            gnt_r       <= REQ_A;
            port_r      <= {PORT_W{1'b0}};
            wr_r        <= 1'b0;
            wdata_r     <= {DATA_W{1'b0}};
            rr_last_r   <= REQ_B;
            sel_valid_r <= 1'b0;
            last_port_r <= {PORT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            gnt_r   <= gnt_nxt_s;
            port_r  <= port_nxt_s;
            wr_r    <= wr_nxt_s;
            wdata_r <= wdata_nxt_s;
            if ((state_r == IDLE) && (grant_s != 2'b00)) begin
                rr_last_r <= grant_s[REQ_B];
            end
            // The selector register latches on the edge leaving SEL_LO.
            if (state_r == SEL_LO) begin
                sel_valid_r <= 1'b1;
                last_port_r <= port_r;
            end
        end
    end

    // Outputs are registered, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            portsel_n_r <= 1'b1;
            port_wr_n_r <= 1'b1;
            port_rd_n_r <= 1'b1;
            ack_a_r     <= 1'b0;
            ack_b_r     <= 1'b0;
            busy_r      <= 1'b0;
            bus_oe_r    <= 1'b0;
            bus_out_r   <= {DATA_W{1'b0}};
            sel_data_r  <= {DATA_W{1'b0}};
            rd_data_r   <= {DATA_W{1'b0}};
        end else begin
            portsel_n_r <= (state_nxt_s != SEL_LO);
            port_wr_n_r <= !((state_nxt_s == STROBE) && wr_nxt_s);
            port_rd_n_r <= !((state_nxt_s == STROBE) && !wr_nxt_s);
            ack_a_r     <= (state_nxt_s == DONE) && (gnt_nxt_s == REQ_A);
            ack_b_r     <= (state_nxt_s == DONE) && (gnt_nxt_s == REQ_B);
            busy_r      <= (state_nxt_s != IDLE);
            bus_oe_r    <= wr_nxt_s && drives_bus(state_nxt_s);
            bus_out_r   <= (wr_nxt_s && drives_bus(state_nxt_s)) ? wdata_nxt_s : {DATA_W{1'b0}};
            if (state_nxt_s == SEL_LO) begin
                sel_data_r <= {{(DATA_W-PORT_W){1'b0}}, port_nxt_s};
            end
            if ((state_r == STROBE) && (cnt_r == 4'd0) && !wr_r) begin
                rd_data_r <= port_bus_in;
            end
        end
    end

    assign _portsel_in  = portsel_n_r;
    assign _port_wr     = port_wr_n_r;
    assign _port_rd     = port_rd_n_r;
    assign ack_a        = ack_a_r;
    assign ack_b        = ack_b_r;
    assign busy         = busy_r;
    assign port_bus_oe  = bus_oe_r;
    assign port_bus_out = bus_out_r;
    assign sel_data     = sel_data_r;
    assign rd_data      = rd_data_r;

endmodule

// File: tb/tb_port_access_sequencer.sv
// Directed bench: default-timing instance driven from a vector table plus
// hand sequences, and a short-timing instance (setup 0, strobe 1, hold 0).
module tb_port_access_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // default-timing instance
    logic       d0_req_a = 1'b0, d0_wr_a = 1'b0, d0_req_b = 1'b0, d0_wr_b = 1'b0;
    logic [3:0] d0_port_a = 4'h0, d0_port_b = 4'h0;
    logic [7:0] d0_wdata_a = 8'h00, d0_wdata_b = 8'h00, d0_bus_in = 8'h00;
    logic       d0_ack_a, d0_ack_b, d0_oe, d0_portsel_n, d0_port_wr, d0_port_rd, d0_busy;
    logic [7:0] d0_rd_data, d0_bus_out, d0_sel_data;

    // short-timing instance
    logic       d1_req_a = 1'b0, d1_wr_a = 1'b0;
    logic [3:0] d1_port_a = 4'h0;
    logic [7:0] d1_wdata_a = 8'h00;
    logic       d1_ack_a, d1_ack_b, d1_oe, d1_portsel_n, d1_port_wr, d1_port_rd, d1_busy;
    logic [7:0] d1_rd_data, d1_bus_out, d1_sel_data;

    port_access_sequencer dut0 (
        .clk(clk), .reset(reset),
        .req_a(d0_req_a), .port_a(d0_port_a), .wr_a(d0_wr_a), .wdata_a(d0_wdata_a), .ack_a(d0_ack_a),
        .req_b(d0_req_b), .port_b(d0_port_b), .wr_b(d0_wr_b), .wdata_b(d0_wdata_b), .ack_b(d0_ack_b),
        .rd_data(d0_rd_data), .port_bus_in(d0_bus_in), .port_bus_out(d0_bus_out),
        .port_bus_oe(d0_oe), .sel_data(d0_sel_data), ._portsel_in(d0_portsel_n),
        ._port_wr(d0_port_wr), ._port_rd(d0_port_rd), .busy(d0_busy)
    );

    port_access_sequencer #(.SETUP_CYC(32'd0), .STROBE_CYC(32'd1), .HOLD_CYC(32'd0)) dut1 (
        .clk(clk), .reset(reset),
        .req_a(d1_req_a), .port_a(d1_port_a), .wr_a(d1_wr_a), .wdata_a(d1_wdata_a), .ack_a(d1_ack_a),
        .req_b(1'b0), .port_b(4'h0), .wr_b(1'b0), .wdata_b(8'h00), .ack_b(d1_ack_b),
        .rd_data(d1_rd_data), .port_bus_in(8'h00), .port_bus_out(d1_bus_out),
        .port_bus_oe(d1_oe), .sel_data(d1_sel_data), ._portsel_in(d1_portsel_n),
        ._port_wr(d1_port_wr), ._port_rd(d1_port_rd), .busy(d1_busy)
    );

    typedef struct {
        string      name;
        logic       is_b;
        logic [3:0] port;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] bus;
        int         lat;
        int         nsel;
        int         nwr;
        int         nrd;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs[6];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One transfer on dut0, observed cycle by cycle until its ack.
    task automatic run_xfer(input vec_t v);
        int lat = -1, nsel = 0, nwr = 0, nrd = 0, bad_seq = 0, overlap = 0, other_ack = 0;
        logic [7:0] sel_seen = 8'hxx;
        logic ack_me, ack_other;
        @(negedge clk);
        if (v.is_b) begin
            d0_req_b = 1'b1; d0_port_b = v.port; d0_wr_b = v.wr; d0_wdata_b = v.wdata;
        end else begin
            d0_req_a = 1'b1; d0_port_a = v.port; d0_wr_a = v.wr; d0_wdata_a = v.wdata;
        end
        d0_bus_in = ~v.bus;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge clk);
            if (!d0_portsel_n) begin nsel++; sel_seen = d0_sel_data; end
            if (!d0_port_wr) nwr++;
            if (!d0_port_rd) nrd++;
            if (!d0_portsel_n && (!d0_port_wr || !d0_port_rd)) overlap++;
            if (!d0_port_wr && !d0_port_rd) overlap++;
            ack_me    = v.is_b ? d0_ack_b : d0_ack_a;
            ack_other = v.is_b ? d0_ack_a : d0_ack_b;
            if (ack_other) other_ack++;
            if (ack_me) begin
                lat = i;
                if (d0_oe) bad_seq++;
            end else if (!d0_busy || (d0_oe !== v.wr) || (v.wr && (d0_bus_out !== v.wdata))) begin
                bad_seq++;
            end
            // only the strobe window presents the real device data
            d0_bus_in = !d0_port_rd ? v.bus : ~v.bus;
        end
        if (v.is_b) d0_req_b = 1'b0;
        else        d0_req_a = 1'b0;
        chk({v.name, "_latency"}, lat, v.lat);
        chk({v.name, "_sel_pulses"}, nsel, v.nsel);
        if (v.nsel > 0) chk({v.name, "_sel_data"}, sel_seen, {4'h0, v.port});
        chk({v.name, "_wr_low_cycles"}, nwr, v.nwr);
        chk({v.name, "_rd_low_cycles"}, nrd, v.nrd);
        chk({v.name, "_bus_busy_seq"}, bad_seq, 0);
        chk({v.name, "_overlap"}, overlap, 0);
        chk({v.name, "_wrong_ack"}, other_ack, 0);
        chk({v.name, "_rd_data"}, d0_rd_data, v.rd);
    endtask

    initial begin
        int acks, gap_pending, overlap, found, sel_idx, stb_idx, nstb, ack_idx;
        logic order[4];
        logic [7:0] d1_out_seen;

        vecs[0] = '{"wr_a_p5",  1'b0, 4'h5, 1'b1, 8'hA5, 8'h00, 7, 1, 2, 0, 8'h00};
        vecs[1] = '{"rd_b_pc",  1'b1, 4'hC, 1'b0, 8'h00, 8'h3C, 7, 1, 0, 2, 8'h3C};
        vecs[2] = '{"wr_a_p3",  1'b0, 4'h3, 1'b1, 8'h5A, 8'h00, 7, 1, 2, 0, 8'h3C};
        vecs[3] = '{"rd_a_p3",  1'b0, 4'h3, 1'b0, 8'h00, 8'h96, 5, 0, 0, 2, 8'h96};
        vecs[4] = '{"wr_b_p3",  1'b1, 4'h3, 1'b1, 8'h11, 8'h00, 5, 0, 2, 0, 8'h96};
        vecs[5] = '{"rd_a_p0",  1'b0, 4'h0, 1'b0, 8'h00, 8'hE7, 7, 1, 0, 2, 8'hE7};

        // reset values
        @(negedge clk); @(negedge clk);
        chk("rst_portsel", d0_portsel_n, 1'b1);
        chk("rst_port_wr", d0_port_wr, 1'b1);
        chk("rst_port_rd", d0_port_rd, 1'b1);
        chk("rst_acks", {d0_ack_a, d0_ack_b}, 2'b00);
        chk("rst_busy", d0_busy, 1'b0);
        chk("rst_oe", d0_oe, 1'b0);
        chk("rst_bus_out", d0_bus_out, 8'h00);
        chk("rst_sel_data", d0_sel_data, 8'h00);
        chk("rst_rd_data", d0_rd_data, 8'h00);
        chk("d1_rst_outs", {d1_portsel_n, d1_port_wr, d1_port_rd, d1_ack_a, d1_ack_b, d1_busy, d1_oe},
            7'b1110000);
        chk("d1_rst_data", {d1_rd_data, d1_bus_out, d1_sel_data}, 24'h000000);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) run_xfer(vecs[k]);

        // both requesters held from reset: grants alternate A, B, A, B
        reset = 1'b1;
        d0_req_a = 1'b1; d0_port_a = 4'h1; d0_wr_a = 1'b1; d0_wdata_a = 8'h77;
        d0_req_b = 1'b1; d0_port_b = 4'h2; d0_wr_b = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        acks = 0; gap_pending = 0; overlap = 0;
        for (int i = 0; i < 80 && acks < 4; i++) begin
            @(negedge clk);
            if (!d0_portsel_n && (!d0_port_wr || !d0_port_rd)) overlap++;
            if (gap_pending != 0) begin
                chk("rr_idle_gap", d0_busy, 1'b0);
                gap_pending = 0;
            end
            if (d0_ack_a || d0_ack_b) begin
                order[acks] = d0_ack_b;
                acks++;
                gap_pending = 1;
            end
        end
        d0_req_a = 1'b0; d0_req_b = 1'b0;
        @(negedge clk);
        chk("rr_idle_gap_last", d0_busy, 1'b0);
        chk("rr_ack_count", acks, 4);
        chk("rr_order", {order[0], order[1], order[2], order[3]}, 4'b0101);
        chk("rr_overlap", overlap, 0);

        // reset in the first strobe cycle of a write
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        d0_req_a = 1'b1; d0_port_a = 4'h7; d0_wr_a = 1'b1; d0_wdata_a = 8'h42;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (!d0_port_wr) found = 1;
        end
        chk("mid_rst_reached_strobe", found, 1);
        reset = 1'b1; d0_req_a = 1'b0;
        @(negedge clk);
        chk("mid_rst_port_wr", d0_port_wr, 1'b1);
        chk("mid_rst_oe", d0_oe, 1'b0);
        chk("mid_rst_busy", d0_busy, 1'b0);
        chk("mid_rst_ack", d0_ack_a, 1'b0);
        reset = 1'b0;
        run_xfer('{"post_rst", 1'b0, 4'h7, 1'b1, 8'h42, 8'h00, 7, 1, 2, 0, 8'h00});

        // short timing: strobe right after SEL_HI, ack 4 cycles after grant
        @(negedge clk);
        d1_req_a = 1'b1; d1_port_a = 4'h9; d1_wr_a = 1'b1; d1_wdata_a = 8'hC3;
        sel_idx = -1; stb_idx = -1; nstb = 0; ack_idx = -1; d1_out_seen = 8'h00;
        for (int i = 1; i <= 20 && ack_idx < 0; i++) begin
            @(negedge clk);
            if (!d1_portsel_n && sel_idx < 0) sel_idx = i;
            if (!d1_port_wr) begin
                nstb++;
                d1_out_seen = d1_bus_out;
                if (stb_idx < 0) stb_idx = i;
            end
            if (d1_ack_a) ack_idx = i;
        end
        d1_req_a = 1'b0;
        chk("short_sel_cycle", sel_idx, 1);
        chk("short_strobe_cycle", stb_idx, 3);
        chk("short_strobe_len", nstb, 1);
        chk("short_ack_latency", ack_idx, 4);
        chk("short_bus_out", d1_out_seen, 8'hC3);
        chk("short_sel_data", d1_sel_data, 8'h09);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/port_access_sequencer.md
Name: port_access_sequencer

Overview:
- Drives the port selector/decoder block. Shares it between two requesters: A is the CPU and B is the DMA/monitor.
- Sequences each transfer: latch the 4-bit port number via a rising edge on _portsel_in, apply setup, pulse the active-low _port_wr or _port_rd strobe, apply hold, then acknowledge.
- Captures read data at the end of the strobe and drives write data onto the port bus for the whole transfer.

Parameters:
SETUP_CYC, 1, cycles from select latched to strobe low (0..15)
STROBE_CYC, 2, cycles the strobe is held low (1..15; 0 illegal, assertion fires at elaboration)
HOLD_CYC, 1, cycles after strobe high with port number and write data still driven (0..15)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
req_a  input  1  requester A transfer request; level, held until ack_a
port_a  input  4  requester A port number
wr_a  input  1  1=write, 0=read
wdata_a  input  8  requester A write data
ack_a  output  1  one-cycle pulse: A transfer complete
req_b, port_b, wr_b, wdata_b, ack_b  as for A, requester B
rd_data  output  8  read data; valid in the ack cycle, held until next read completes
port_bus_in  input  8  data returned by the selected device
port_bus_out  output  8  write data to devices
port_bus_oe  output  1  1 while a write transfer owns the bus
sel_data  output  8  to selector register data input: {4'b0, port}
_portsel_in  output  1  selector register clock; rising edge latches sel_data
_port_wr  output  1  active-low write strobe to decoder enable
_port_rd  output  1  active-low read strobe to decoder enable
busy  output  1  1 in any state except IDLE

Behaviour:
- Reset values: _portsel_in=1, _port_wr=1, _port_rd=1, ack_a=ack_b=0, busy=0, port_bus_oe=0, port_bus_out=0, sel_data=0, rd_data=0.
- Reset also sets: state=IDLE, rr_last=B (so A wins the first tie), sel_valid=0.
- Reset mid-transfer: all strobes return high on the next edge and no ack is issued.
- Arbitration in IDLE:
  - A single requester is granted.
  - If both request, round-robin against rr_last.
  - The grant and the request fields (port, wr, wdata) are registered on the grant edge. Later changes to the inputs are ignored.
- State sequence:
  - IDLE -> SEL_LO: _portsel_in=0, sel_data driven.
  - SEL_LO -> SEL_HI: _portsel_in=1, creating the rising edge.
  - SEL_HI -> SETUP.
  - SETUP lasts SETUP_CYC cycles; when SETUP_CYC=0, SEL_HI goes straight to STROBE.
  - STROBE lasts STROBE_CYC cycles with _port_wr or _port_rd low.
  - HOLD lasts HOLD_CYC cycles.
  - DONE lasts one cycle: ack to the granted requester, then IDLE.
- Select skip: if sel_valid=1 and the granted port equals last_port, IDLE goes directly to SETUP with no _portsel_in pulse.
- Pulse guarantees: _portsel_in low for exactly one cycle. The strobe is never low in the same cycle as _portsel_in=0 or in SEL_HI.
- Write transfers: port_bus_oe=1 and port_bus_out=wdata from SEL_LO (or SETUP if skipped) through HOLD inclusive.
- Read transfers: rd_data <= port_bus_in on the edge ending the last STROBE cycle.
- Latency for SEL, SETUP_CYC=s, STROBE_CYC=t, HOLD_CYC=h:
  - Full transfer: 3+s+t+h cycles from grant to ack (default 7).
  - Skip path: 2 fewer cycles.
- Back-to-back transfers: a requester still asserting req in its ack cycle is treated as a new request. That new request is arbitrated in the next IDLE cycle, so there is at least one IDLE cycle between transfers.
- A single cycle counter is shared by SETUP, STROBE and HOLD. It is 4 bits, loaded with N-1 on entry and decremented; the state exits at 0.
- Only one strobe is ever low at a time; an assertion checks this.

Decomposition:
- Shared package port_seq_pkg holds:
  - state enum: IDLE, SEL_LO, SEL_HI, SETUP, STROBE, HOLD, DONE
  - requester id constants REQ_A=0, REQ_B=1
  - PORT_W=4, DATA_W=8
- Sub-module port_rr_arbiter: 2-way round-robin, req[1:0] and rr_last in, grant[1:0] out; combinational, with rr_last updated by the parent on grant.

Test Plan:
- Write, A only, port 5, data 0xA5, defaults:
  - sel_data=0x05 and _portsel_in low for 1 cycle; _port_wr low for exactly 2 cycles.
  - port_bus_out=0xA5 with oe=1 throughout; ack_a 7 cycles after grant; _port_rd stays high.
- Read, B only, port 0xC, port_bus_in=0x3C during strobe: rd_data=0x3C in the ack_b cycle; _port_rd low 2 cycles; port_bus_oe=0 throughout.
- A and B both requesting continuously from reset: grants alternate A, B, A, B; each ack is separated by at least one IDLE cycle; no _portsel_in pulse overlaps a strobe.
- Same port twice, A writes port 3 then reads port 3: the second transfer has no _portsel_in pulse and its ack arrives 5 cycles after grant.
- SETUP_CYC=0, HOLD_CYC=0, STROBE_CYC=1: strobe goes low in the cycle immediately after SEL_HI; ack 4 cycles after grant.
- reset asserted in the 1st STROBE cycle of a write: next edge gives _port_wr=1, oe=0, busy=0, no ack; a following A request to the same port performs a full select pulse (sel_valid was cleared).
